// File: rtl/nn_pkg.sv
// Shared definitions for the neural-network layer blocks: activation
// encodings, the layer state enumeration and accumulator sizing.
package nn_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_RSVD  = 2'd3
    } act_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        WB   = 2'd2,
        DONE = 2'd3
    } layer_state_e;

    // Leaky ReLU slope is 1/8, applied as an arithmetic right shift.
    localparam int unsigned LeakyShift = 3;

    // Wide enough to hold PreN full-scale signed products without overflow.
    function automatic int unsigned acc_width(input int unsigned data_width,
                                              input int unsigned pre_n);
        return 2 * data_width + $clog2(pre_n) + 1;
    endfunction

endpackage

// File: rtl/layer_tm_if.sv
// Handshake and data bundle of one layer: input vector in, result vector out.
// The layer is the slave; the producer/consumer side is the master.
interface layer_tm_if #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned N         = 10,
    parameter int unsigned PreN      = 10
) ();

    logic [1:0]                  act_mode;
    logic                        in_valid;
    logic                        in_ready;
    logic [DataWidth*PreN-1:0]   Input_Data_ThisLayer;
    logic [DataWidth*N*PreN-1:0] Weights_ThisLayer;
    logic [DataWidth*N-1:0]      Bias_ThisLayer;
    logic                        out_valid;
    logic                        out_ready;
    logic [DataWidth*N-1:0]      Output_Data_ThisLayer;

    modport slave (
        input  act_mode, in_valid, Input_Data_ThisLayer, Weights_ThisLayer,
               Bias_ThisLayer, out_ready,
        output in_ready, out_valid, Output_Data_ThisLayer
    );

    modport master (
        output act_mode, in_valid, Input_Data_ThisLayer, Weights_ThisLayer,
               Bias_ThisLayer, out_ready,
        input  in_ready, out_valid, Output_Data_ThisLayer
    );

endinterface

// File: rtl/layer_tm_mac_lane.sv
// One multiply-accumulate lane: accumulates w*x products, and presents the
// biased, rescaled, activated and saturated result of the accumulator.
module mac_lane
    import nn_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned PreN      = 10,
    parameter int unsigned FracBits  = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_mac_en,
    input  logic                 i_clear,
    input  logic [DataWidth-1:0] i_x,
    input  logic [DataWidth-1:0] i_w,
    input  logic [DataWidth-1:0] i_bias,
    input  act_mode_e            i_act,
    output logic [DataWidth-1:0] o_result
);

    localparam int unsigned AccW = acc_width(DataWidth, PreN);
    // One extra bit so the bias addition can never wrap.
    localparam int unsigned SumW = AccW + 1;

    localparam logic signed [SumW-1:0] SatMax = SumW'((2 ** (DataWidth - 1)) - 1);
    localparam logic signed [SumW-1:0] SatMin = -SatMax - 1;

    logic signed [AccW-1:0]        r_acc;
    logic signed [2*DataWidth-1:0] w_prod;
    logic signed [SumW-1:0]        w_sum;
    logic signed [SumW-1:0]        w_r;
    logic signed [SumW-1:0]        w_act;
    logic signed [SumW-1:0]        w_sat;

    assign w_prod = $signed(i_x) * $signed(i_w);

    // Accumulator: cleared on write-back, otherwise sums one product per MAC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (i_clear) begin
            r_acc <= '0;
        end else if (i_mac_en) begin
            r_acc <= r_acc + AccW'(w_prod);
        end
    end

    // Bias, rescale to the data format, activate and clamp to DataWidth.
    always_comb begin
        w_sum = SumW'(r_acc) + (SumW'($signed(i_bias)) <<< FracBits);
        w_r   = w_sum >>> FracBits;
        w_act = w_r;
        case (i_act)
            ACT_RELU:  if (w_r[SumW-1]) w_act = '0;
            ACT_LEAKY: if (w_r[SumW-1]) w_act = w_r >>> LeakyShift;
            default:   w_act = w_r;
        endcase
        w_sat = w_act;
        if (w_act > SatMax) begin
            w_sat = SatMax;
        end else if (w_act < SatMin) begin
            w_sat = SatMin;
        end
        o_result = w_sat[DataWidth-1:0];
    end

endmodule

// File: rtl/layer_tm.sv
// Fully-connected layer: accepts an input vector, computes N neurons in
// groups of Lanes parallel MAC lanes, and holds the result vector until taken.
module layer_tm
    import nn_pkg::*;
#(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned N         = 10,
    parameter int unsigned PreN      = 10,
    parameter int unsigned Lanes     = 2,
    parameter int unsigned FracBits  = 4
) (
    input logic       clk,
    input logic       rst_n,
    layer_tm_if.slave bus
);

    localparam int unsigned Groups = (N + Lanes - 1) / Lanes;
    localparam int unsigned GW     = $clog2(Groups + 1);
    localparam int unsigned JW     = $clog2(PreN + 1);

    layer_state_e              r_state;
    layer_state_e              w_next_state;
    logic [GW-1:0]             r_g;
    logic [JW-1:0]             r_j;
    logic [DataWidth*PreN-1:0] r_x;
    act_mode_e                 r_act;
    logic [DataWidth*N-1:0]    r_out;

    logic                      w_in_ready;
    logic                      w_out_valid;
    logic                      w_last_j;
    logic                      w_last_g;
    logic                      w_mac_en;
    logic                      w_clear;
    logic [DataWidth-1:0]      w_x;
    logic [31:0]               w_nsafe     [Lanes];
    logic                      w_lane_valid[Lanes];
    logic [DataWidth-1:0]      w_lane_w    [Lanes];
    logic [DataWidth-1:0]      w_lane_b    [Lanes];
    logic [DataWidth-1:0]      w_lane_res  [Lanes];

    assign w_last_j = (r_j == JW'(PreN - 1));
    assign w_last_g = (r_g == GW'(Groups - 1));
    assign w_mac_en = (r_state == MAC);
    assign w_clear  = (r_state == WB);
    assign w_x      = r_x[DataWidth*r_j +: DataWidth];

    assign bus.in_ready              = w_in_ready;
    assign bus.out_valid             = w_out_valid;
    assign bus.Output_Data_ThisLayer = r_out;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake outputs; in_ready is held low while in reset.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = rst_n;
                if (bus.in_valid) w_next_state = MAC;
            end
            MAC: begin
                if (w_last_j) w_next_state = WB;
            end
            WB: begin
                w_next_state = w_last_g ? DONE : MAC;
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Per-lane operand selection; lanes past the last neuron see zero operands
    // and a clamped index so no out-of-range slice is ever read.
    always_comb begin
        for (int unsigned l = 0; l < Lanes; l++) begin
            w_nsafe[l]      = 32'(r_g) * Lanes + l;
            w_lane_valid[l] = (w_nsafe[l] < N);
            if (!w_lane_valid[l]) w_nsafe[l] = '0;
            w_lane_w[l] = '0;
            if (w_lane_valid[l]) begin
                w_lane_w[l] = bus.Weights_ThisLayer[DataWidth*(PreN*w_nsafe[l] + 32'(r_j)) +: DataWidth];
            end
            w_lane_b[l] = bus.Bias_ThisLayer[DataWidth*w_nsafe[l] +: DataWidth];
        end
    end

    // Sequencing counters, latched inputs and the registered result vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g   <= '0;
            r_j   <= '0;
            r_x   <= '0;
            r_act <= ACT_NONE;
            r_out <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.in_valid) begin
                        r_x   <= bus.Input_Data_ThisLayer;
                        r_act <= act_mode_e'(bus.act_mode);
                        r_g   <= '0;
                        r_j   <= '0;
                    end
                end
                MAC: begin
                    r_j <= w_last_j ? '0 : r_j + JW'(1);
                end
                WB: begin
                    if (!w_last_g) r_g <= r_g + GW'(1);
                    for (int unsigned l = 0; l < Lanes; l++) begin
                        if (w_lane_valid[l]) begin
                            r_out[DataWidth*w_nsafe[l] +: DataWidth] <= w_lane_res[l];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    for (genvar l = 0; l < Lanes; l++) begin : g_lane
        mac_lane #(
            .DataWidth(DataWidth),
            .PreN     (PreN),
            .FracBits (FracBits)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_mac_en(w_mac_en),
            .i_clear (w_clear),
            .i_x     (w_x),
            .i_w     (w_lane_w[l]),
            .i_bias  (w_lane_b[l]),
            .i_act   (r_act),
            .o_result(w_lane_res[l])
        );
    end

endmodule

// File: tb/tb_layer_tm.sv
// Directed bench for layer_tm using three parameterisations: a 3-neuron
// 2-lane layer, a single 4-input neuron, and a 1-input fixed-point neuron.
module tb_layer_tm;

    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    layer_tm_if #(.DataWidth(8), .N(3), .PreN(2)) bus_a ();
    layer_tm_if #(.DataWidth(8), .N(1), .PreN(4)) bus_b ();
    layer_tm_if #(.DataWidth(8), .N(1), .PreN(1)) bus_c ();

    layer_tm #(.DataWidth(8), .N(3), .PreN(2), .Lanes(2), .FracBits(0))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
    layer_tm #(.DataWidth(8), .N(1), .PreN(4), .Lanes(1), .FracBits(0))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
    layer_tm #(.DataWidth(8), .N(1), .PreN(1), .Lanes(1), .FracBits(4))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

    // Present a vector to dut_a and count cycles (accept edge = 1) until out_valid.
    task automatic start_a(input logic [15:0] x, input logic [47:0] w,
                           input logic [23:0] b, input logic [1:0] act,
                           output int lat);
        bus_a.Input_Data_ThisLayer = x;
        bus_a.Weights_ThisLayer    = w;
        bus_a.Bias_ThisLayer       = b;
        bus_a.act_mode             = act;
        bus_a.in_valid             = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        lat = 1;
        while (!bus_a.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic handshake_a();
        bus_a.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_a.out_ready = 1'b0;
    endtask

    task automatic run_b(input logic [31:0] x, input logic [31:0] w,
                         input logic [7:0] b, input logic [1:0] act,
                         output logic [7:0] res, output int lat);
        bus_b.Input_Data_ThisLayer = x;
        bus_b.Weights_ThisLayer    = w;
        bus_b.Bias_ThisLayer       = b;
        bus_b.act_mode             = act;
        bus_b.in_valid             = 1'b1;
        @(posedge clk); #1;
        bus_b.in_valid = 1'b0;
        lat = 1;
        while (!bus_b.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus_b.Output_Data_ThisLayer;
        bus_b.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_b.out_ready = 1'b0;
    endtask

    task automatic run_c(input logic [7:0] x, input logic [7:0] w,
                         input logic [7:0] b, input logic [1:0] act,
                         output logic [7:0] res, output int lat);
        bus_c.Input_Data_ThisLayer = x;
        bus_c.Weights_ThisLayer    = w;
        bus_c.Bias_ThisLayer       = b;
        bus_c.act_mode             = act;
        bus_c.in_valid             = 1'b1;
        @(posedge clk); #1;
        bus_c.in_valid = 1'b0;
        lat = 1;
        while (!bus_c.out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = bus_c.Output_Data_ThisLayer;
        bus_c.out_ready = 1'b1;
        @(posedge clk); #1;
        bus_c.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", bus_a.in_ready); end
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'h0) begin errors++; $display("FAIL reset_out_a: got %h expected 000000", bus_a.Output_Data_ThisLayer); end
        checks++; if (bus_b.Output_Data_ThisLayer !== 8'h0) begin errors++; $display("FAIL reset_out_b: got %h expected 00", bus_b.Output_Data_ThisLayer); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", bus_a.in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready: got %b expected 1", bus_a.in_ready); end
        start_a(16'h0201, 48'h0101_0101_0101, 24'h000000, 2'd1, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL basic_latency: got %0d expected 7", lat); end
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'h030303) begin errors++; $display("FAIL basic_out: got %h expected 030303", bus_a.Output_Data_ThisLayer); end
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL basic_busy_ready: got %b expected 0", bus_a.in_ready); end
        handshake_a();
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL basic_ready_back: got %b expected 1", bus_a.in_ready); end
    endtask

    // Mixed signs, bias and leaky activation across a partial last group.
    task automatic test_leaky_bias();
        int lat;
        start_a(16'hFE03, 48'hFFFF_0401_0102, 24'hE20001, 2'd2, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL leaky_latency: got %0d expected 7", lat); end
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'hFCFF05) begin errors++; $display("FAIL leaky_out: got %h expected fcff05", bus_a.Output_Data_ThisLayer); end
        handshake_a();
    endtask

    task automatic test_stall();
        int lat;
        start_a(16'h0201, 48'h0101_0101_0101, 24'h000000, 2'd1, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL stall_latency: got %0d expected 7", lat); end
        for (int i = 0; i < 5; i++) begin
            if (i == 2) begin
                bus_a.Input_Data_ThisLayer = 16'h0505;
                bus_a.in_valid = 1'b1;
            end
            @(posedge clk); #1;
            bus_a.in_valid = 1'b0;
            checks++; if (bus_a.out_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b expected 1", i, bus_a.out_valid); end
            checks++; if (bus_a.Output_Data_ThisLayer !== 24'h030303) begin errors++; $display("FAIL stall_data[%0d]: got %h expected 030303", i, bus_a.Output_Data_ThisLayer); end
            checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 0", i, bus_a.in_ready); end
        end
        handshake_a();
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL stall_ready_back: got %b expected 1", bus_a.in_ready); end
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL stall_no_queue: got %b expected 0", bus_a.out_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bus_a.Input_Data_ThisLayer = 16'hFE03;
        bus_a.Weights_ThisLayer    = 48'hFFFF_0401_0102;
        bus_a.Bias_ThisLayer       = 24'hE20001;
        bus_a.act_mode             = 2'd2;
        bus_a.in_valid             = 1'b1;
        @(posedge clk); #1;
        bus_a.in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        // Group 0 has written slots 0 and 1; slot 2 still holds the old result.
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'h03FF05) begin errors++; $display("FAIL mid_partial: got %h expected 03ff05", bus_a.Output_Data_ThisLayer); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'h0) begin errors++; $display("FAIL mid_rst_out: got %h expected 000000", bus_a.Output_Data_ThisLayer); end
        checks++; if (bus_a.out_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", bus_a.out_valid); end
        checks++; if (bus_a.in_ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready: got %b expected 0", bus_a.in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++; if (bus_a.in_ready !== 1'b1) begin errors++; $display("FAIL mid_rel_ready: got %b expected 1", bus_a.in_ready); end
        start_a(16'h0201, 48'h0101_0101_0101, 24'h000000, 2'd1, lat);
        checks++; if (lat !== 7) begin errors++; $display("FAIL mid_latency: got %0d expected 7", lat); end
        checks++; if (bus_a.Output_Data_ThisLayer !== 24'h030303) begin errors++; $display("FAIL mid_out: got %h expected 030303", bus_a.Output_Data_ThisLayer); end
        handshake_a();
    endtask

    // Sum of -20 through each activation mode (3 = reserved behaves as none).
    task automatic test_activation();
        logic [7:0] res;
        int lat;
        run_b(32'hFBFB_FBFB, 32'h0101_0101, 8'h00, 2'd0, res, lat);
        checks++; if (lat !== 6) begin errors++; $display("FAIL act_latency: got %0d expected 6", lat); end
        checks++; if (res !== 8'hEC) begin errors++; $display("FAIL act_none: got %h expected ec", res); end
        run_b(32'hFBFB_FBFB, 32'h0101_0101, 8'h00, 2'd1, res, lat);
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL act_relu: got %h expected 00", res); end
        run_b(32'hFBFB_FBFB, 32'h0101_0101, 8'h00, 2'd2, res, lat);
        checks++; if (res !== 8'hFD) begin errors++; $display("FAIL act_leaky: got %h expected fd", res); end
        run_b(32'hFBFB_FBFB, 32'h0101_0101, 8'h00, 2'd3, res, lat);
        checks++; if (res !== 8'hEC) begin errors++; $display("FAIL act_reserved: got %h expected ec", res); end
    endtask

    task automatic test_saturation();
        logic [7:0] res;
        int lat;
        run_b(32'h7F7F_7F7F, 32'h7F7F_7F7F, 8'h00, 2'd0, res, lat);
        checks++; if (res !== 8'h7F) begin errors++; $display("FAIL sat_pos: got %h expected 7f", res); end
        run_b(32'h8080_8080, 32'h7F7F_7F7F, 8'h00, 2'd0, res, lat);
        checks++; if (res !== 8'h80) begin errors++; $display("FAIL sat_neg: got %h expected 80", res); end
        run_b(32'h7F7F_7F7F, 32'h7F7F_7F7F, 8'h7F, 2'd1, res, lat);
        checks++; if (res !== 8'h7F) begin errors++; $display("FAIL sat_relu: got %h expected 7f", res); end
    endtask

    task automatic test_fixed_point();
        logic [7:0] res;
        int lat;
        run_c(8'h10, 8'h18, 8'h08, 2'd0, res, lat);
        checks++; if (lat !== 3) begin errors++; $display("FAIL fx_latency: got %0d expected 3", lat); end
        checks++; if (res !== 8'h20) begin errors++; $display("FAIL fx_basic: got %h expected 20", res); end
        run_c(8'h01, 8'hFF, 8'h00, 2'd0, res, lat);
        checks++; if (res !== 8'hFF) begin errors++; $display("FAIL fx_floor: got %h expected ff", res); end
        run_c(8'h10, 8'hE8, 8'h00, 2'd1, res, lat);
        checks++; if (res !== 8'h00) begin errors++; $display("FAIL fx_relu: got %h expected 00", res); end
        run_c(8'h10, 8'hE8, 8'h00, 2'd0, res, lat);
        checks++; if (res !== 8'hE8) begin errors++; $display("FAIL fx_neg: got %h expected e8", res); end
        run_c(8'h7F, 8'h7F, 8'h7F, 2'd0, res, lat);
        checks++; if (res !== 8'h7F) begin errors++; $display("FAIL fx_sat: got %h expected 7f", res); end
    endtask

    initial begin
        rst_n = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b0; bus_a.act_mode = 2'd0;
        bus_a.Input_Data_ThisLayer = '0; bus_a.Weights_ThisLayer = '0; bus_a.Bias_ThisLayer = '0;
        bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b0; bus_b.act_mode = 2'd0;
        bus_b.Input_Data_ThisLayer = '0; bus_b.Weights_ThisLayer = '0; bus_b.Bias_ThisLayer = '0;
        bus_c.in_valid = 1'b0; bus_c.out_ready = 1'b0; bus_c.act_mode = 2'd0;
        bus_c.Input_Data_ThisLayer = '0; bus_c.Weights_ThisLayer = '0; bus_c.Bias_ThisLayer = '0;

        test_reset();
        test_basic();
        test_leaky_bias();
        test_stall();
        test_reset_mid();
        test_activation();
        test_saturation();
        test_fixed_point();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

endmodule

// File: doc/layer_tm.md
LAYER_TM -- requirements
Module: layer_tm

Interface
REQ-001 SHALL have parameter DataWidth, default 8: signed two's-complement width of data, weights, bias and results.
REQ-002 SHALL have parameter N, default 10: neurons in this layer.
REQ-003 SHALL have parameter PreN, default 10: inputs per neuron, i.e. previous-layer neurons.
REQ-004 SHALL have parameter Lanes, default 2: parallel MAC lanes, range 1..N; N need not be a multiple of Lanes.
REQ-005 SHALL have parameter FracBits, default 4: fractional bits of the fixed-point format.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-008 SHALL have port act_mode, input, 2 bits: activation select, 0=none, 1=relu, 2=leaky relu, 3=reserved (treated as none); sampled at input accept.
REQ-009 SHALL have port in_valid, input, 1 bit: input vector valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block can accept an input vector.
REQ-011 SHALL have port Input_Data_ThisLayer, input, DataWidth*PreN bits: input vector; element j at [DataWidth*j +: DataWidth].
REQ-012 SHALL have port Weights_ThisLayer, input, DataWidth*N*PreN bits: weight of neuron i, input j at [DataWidth*(PreN*i+j) +: DataWidth]; held stable by the source from accept until output handshake.
REQ-013 SHALL have port Bias_ThisLayer, input, DataWidth*N bits: bias of neuron i at [DataWidth*i +: DataWidth]; same stability rule as weights.
REQ-014 SHALL have port out_valid, output, 1 bit: result vector valid.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accepts the result vector.
REQ-016 SHALL have port Output_Data_ThisLayer, output, DataWidth*N bits, registered: neuron i result at [DataWidth*i +: DataWidth].

Function
REQ-017 SHALL implement a state machine with states IDLE, MAC, WB, DONE.
REQ-018 SHALL drive in_ready=1 only in IDLE; accept occurs on in_valid&&in_ready, latching the input vector and act_mode and moving to MAC with group g=0, input index j=0.
REQ-019 SHALL, in MAC, add w[g*Lanes+l][j]*x[j] into accumulator l for every lane l each cycle, advancing j; after j=PreN-1 the state SHALL go to WB.
REQ-020 SHALL size accumulators at 2*DataWidth+$clog2(PreN)+1 bits so that no intermediate overflow occurs.
REQ-021 SHALL, in WB (one cycle), compute per lane r = (acc + (bias<<<FracBits)) >>> FracBits (arithmetic shift, floor), then apply the activation (relu: r<0 gives 0; leaky: r<0 gives r>>>3), saturate to [-2^(DataWidth-1), 2^(DataWidth-1)-1], write the result to its output slot and clear the accumulators.
REQ-022 SHALL ignore lanes whose neuron index is >=N in the last group, leaving unused output slots unwritten.
REQ-023 SHALL, after WB, go to MAC with g+1 and j=0 if neurons remain, otherwise to DONE.
REQ-024 SHALL give a latency from accept to out_valid of exactly ceil(N/Lanes)*(PreN+1)+1 cycles.
REQ-025 SHALL assert out_valid only in DONE and hold it, with Output_Data_ThisLayer stable, until out_ready; on out_valid&&out_ready the state SHALL go to IDLE, and in_ready rises on the following cycle.
REQ-026 SHALL ignore in_valid while not in IDLE, with no queueing.

Reset
REQ-027 SHALL, while rst_n=0 and at any time including mid-computation, immediately force state IDLE, in_ready=0 during reset, out_valid=0, Output_Data_ThisLayer=0, all accumulators, counters and latched inputs=0, with in_ready=1 on the first cycle after release.

Structure
REQ-028 SHALL take the act_mode encodings, the state enumeration and an accumulator-width function from the shared package nn_pkg.
REQ-029 SHALL instantiate one sub-module, mac_lane (multiply-accumulate, clear, bias/shift/activate/saturate), Lanes times via generate.

Verification
REQ-030 SHALL cover: N=3, PreN=2, Lanes=2, FracBits=0, x={1,2}, all w=1, b=0, relu -> outputs {3,3,3}, out_valid at cycle 2*3+1=7.
REQ-031 SHALL cover: one neuron with sum -20, relu -> 0; leaky -> -3; none -> -20.
REQ-032 SHALL cover: DataWidth=8, FracBits=0, x=127, w=127, PreN=4 -> result saturates to 127; all -128 with w=127 -> -128.
REQ-033 SHALL cover: out_ready held 0 for 5 cycles -> out_valid and data stable, in_ready=0, and an in_valid pulse ignored.
REQ-034 SHALL cover: rst_n pulsed low in the middle of MAC -> outputs 0 at once, and a new vector after release gives the correct result with no residue.
REQ-035 SHALL cover: FracBits=4, x=0x10 (1.0), w=0x18 (1.5), b=0x08 (0.5), PreN=1 -> 0x20.
